// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: two queued writers share one
// registered write port; pend flags registers with writes in flight.

module regfile_wport_fifo #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [4:0]   in_addr,
  input  logic [N-1:0] in_data,
  input  logic         pop,
  output logic         full,
  output logic         nonempty,
  output logic [4:0]   head_addr,
  output logic [N-1:0] head_data,
  output logic [31:0]  mask
);
  localparam int AW = $clog2(DEPTH);

  logic [4:0]   addr_q [DEPTH];
  logic [N-1:0] data_q [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [AW:0]   cnt;
  logic [AW-1:0] off;

  assign full      = (cnt == (AW+1)'(DEPTH));
  assign nonempty  = (cnt != '0);
  assign head_addr = addr_q[rd];
  assign head_data = data_q[rd];

  // pointers and occupancy; reset discards every queued entry
  always_ff @(posedge clk) begin
    if (reset) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // entry storage needs no reset, occupancy qualifies it
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_q[wr] <= in_addr;
      data_q[wr] <= in_data;
    end
  end

  // destination bitmap of the occupied entries, X31 excluded
  always_comb begin
    mask = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd;
      if ({1'b0, off} < cnt) mask[addr_q[i]] = 1'b1;
    end
    mask[31] = 1'b0;
  end
endmodule

module regfile_wport_arbiter #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic [31:0]  pend
);
  logic         a_full, b_full;
  logic         a_ne, b_ne;
  logic [4:0]   a_haddr, b_haddr;
  logic [N-1:0] a_hdata, b_hdata;
  logic [31:0]  a_mask, b_mask;
  logic         gnt_a, gnt_b;
  logic         rr_b;

  assign a_ready = !reset && !a_full;
  assign b_ready = !reset && !b_full;

  regfile_wport_fifo #(.N(N), .DEPTH(DEPTH)) u_fa (
    .clk       (clk),
    .reset     (reset),
    .push      (a_valid && a_ready),
    .in_addr   (a_addr),
    .in_data   (a_data),
    .pop       (gnt_a),
    .full      (a_full),
    .nonempty  (a_ne),
    .head_addr (a_haddr),
    .head_data (a_hdata),
    .mask      (a_mask)
  );

  regfile_wport_fifo #(.N(N), .DEPTH(DEPTH)) u_fb (
    .clk       (clk),
    .reset     (reset),
    .push      (b_valid && b_ready),
    .in_addr   (b_addr),
    .in_data   (b_data),
    .pop       (gnt_b),
    .full      (b_full),
    .nonempty  (b_ne),
    .head_addr (b_haddr),
    .head_data (b_hdata),
    .mask      (b_mask)
  );

  // round-robin grant: on a tie, favour whoever did not win last
  always_comb begin
    gnt_a = a_ne && (!b_ne || rr_b);
    gnt_b = b_ne && (!a_ne || !rr_b);
  end

  // last-winner flag, set to B at reset so A wins the first tie
  always_ff @(posedge clk) begin
    if (reset)      rr_b <= 1'b1;
    else if (gnt_a) rr_b <= 1'b0;
    else if (gnt_b) rr_b <= 1'b1;
  end

  // registered write stage; X31 passes through but never enables
  always_ff @(posedge clk) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (gnt_a) begin
      we3 <= (a_haddr != 5'd31);
      wa3 <= a_haddr;
      wd3 <= a_hdata;
    end else if (gnt_b) begin
      we3 <= (b_haddr != 5'd31);
      wa3 <= b_haddr;
      wd3 <= b_hdata;
    end else begin
      we3 <= 1'b0;
    end
  end

  // in-flight bitmap: both queues plus the staged write
  always_comb begin
    pend = a_mask | b_mask;
    if (we3) pend[wa3] = 1'b1;
    pend[31] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter.
// Linear steps, immediate assertions at each check point.

module tb_regfile_wport_arbiter;
  logic        clk;
  logic        reset;
  logic        a_valid, a_ready;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        b_valid, b_ready;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [31:0] pend;

  int total = 0;
  int bad   = 0;

  regfile_wport_arbiter #(.N(64), .DEPTH(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .we3     (we3),
    .wa3     (wa3),
    .wd3     (wd3),
    .pend    (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic put_a(input logic [4:0] ad, input logic [63:0] d);
    a_valid = 1'b1;
    a_addr  = ad;
    a_data  = d;
  endtask

  task automatic put_b(input logic [4:0] ad, input logic [63:0] d);
    b_valid = 1'b1;
    b_addr  = ad;
    b_data  = d;
  endtask

  logic [4:0]  exp_addr [8];
  logic [63:0] exp_data [8];
  int ai, bi, k;
  logic acc_a, acc_b;

  initial begin
    reset = 1'b1;
    idle();
    a_addr = '0; a_data = '0;
    b_addr = '0; b_data = '0;
    tick();
    tick();
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_pend", pend, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", a_ready, 1);
    chk("post_rst_b_ready", b_ready, 1);

    // single write from A
    put_a(5'd5, 64'hDEAD);
    tick();
    idle();
    chk("s1_pend_e0", pend, 32'h20);
    chk("s1_we3_e0", we3, 0);
    tick();
    chk("s1_we3_e1", we3, 1);
    chk("s1_wa3_e1", wa3, 5);
    chk("s1_wd3_e1", wd3, 64'hDEAD);
    chk("s1_pend_e1", pend, 32'h20);
    tick();
    chk("s1_we3_e2", we3, 0);
    chk("s1_pend_e2", pend, 0);
    chk("s1_wa3_hold", wa3, 5);

    // fresh round-robin state for the tie test
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // two back-to-back ties
    put_a(5'd1, 64'h11);
    put_b(5'd2, 64'h22);
    tick();
    chk("t_pend_e0", pend, 32'h6);
    put_a(5'd3, 64'h33);
    put_b(5'd4, 64'h44);
    tick();
    idle();
    chk("t_wa3_1", wa3, 1);
    chk("t_wd3_1", wd3, 64'h11);
    chk("t_pend_1", pend, 32'h1E);
    tick();
    chk("t_wa3_2", wa3, 2);
    chk("t_wd3_2", wd3, 64'h22);
    chk("t_pend_2", pend, 32'h1C);
    tick();
    chk("t_wa3_3", wa3, 3);
    chk("t_wd3_3", wd3, 64'h33);
    chk("t_pend_3", pend, 32'h18);
    tick();
    chk("t_wa3_4", wa3, 4);
    chk("t_wd3_4", wd3, 64'h44);
    chk("t_pend_4", pend, 32'h10);
    tick();
    chk("t_we3_idle", we3, 0);
    chk("t_pend_idle", pend, 0);

    // both sides saturating: backpressure and alternation
    for (int j = 0; j < 4; j++) begin
      exp_addr[2*j]   = 5'(8 + j);
      exp_data[2*j]   = 64'hA0 + 64'(j);
      exp_addr[2*j+1] = 5'(16 + j);
      exp_data[2*j+1] = 64'hB0 + 64'(j);
    end
    ai = 0; bi = 0; k = 0;
    for (int i = 0; i < 12; i++) begin
      a_valid = (ai < 4);
      a_addr  = 5'(8 + ai);
      a_data  = 64'hA0 + 64'(ai);
      b_valid = (bi < 4);
      b_addr  = 5'(16 + bi);
      b_data  = 64'hB0 + 64'(bi);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick();
      if (acc_a) ai++;
      if (acc_b) bi++;
      if (i == 1) chk("bp_b_ready_full", b_ready, 0);
      if (i == 2) begin
        chk("bp_a_ready_full", a_ready, 0);
        chk("bp_b_ready_back", b_ready, 1);
      end
      if (we3) begin
        if (k < 8) begin
          chk($sformatf("bp_wa3_%0d", k), wa3, exp_addr[k]);
          chk($sformatf("bp_wd3_%0d", k), wd3, exp_data[k]);
        end
        k++;
      end
    end
    idle();
    chk("bp_write_count", k, 8);
    chk("bp_pend_drained", pend, 0);

    // X31 write is consumed without a regfile write
    put_a(5'd31, 64'h1234);
    tick();
    idle();
    chk("z_pend_e0", pend, 0);
    chk("z_a_ready", a_ready, 1);
    tick();
    chk("z_we3", we3, 0);
    chk("z_wa3", wa3, 31);
    chk("z_pend_e1", pend, 0);
    tick();
    chk("z_we3_after", we3, 0);

    // same register from both sides; A won last so B goes first
    put_a(5'd7, 64'hAA);
    put_b(5'd7, 64'hBB);
    tick();
    idle();
    chk("x7_pend_e0", pend, 32'h80);
    tick();
    chk("x7_wd3_first", wd3, 64'hBB);
    chk("x7_pend_e1", pend, 32'h80);
    tick();
    chk("x7_wd3_second", wd3, 64'hAA);
    chk("x7_pend_e2", pend, 32'h80);
    tick();
    chk("x7_pend_e3", pend, 0);

    // reset while both queues hold data
    for (int i = 0; i < 3; i++) begin
      put_a(5'd10, 64'hC0 + 64'(i));
      put_b(5'd11, 64'hD0 + 64'(i));
      tick();
    end
    idle();
    reset = 1'b1;
    tick();
    chk("r6_we3", we3, 0);
    chk("r6_pend", pend, 0);
    chk("r6_wd3", wd3, 0);
    chk("r6_a_ready_rst", a_ready, 0);
    reset = 1'b0;
    #1;
    chk("r6_a_ready", a_ready, 1);
    chk("r6_b_ready", b_ready, 1);
    tick();
    chk("r6_we3_next", we3, 0);
    chk("r6_pend_next", pend, 0);
    tick();
    chk("r6_we3_later", we3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
